// File: rtl/serial_word_feeder.sv
// Word FIFO feeding a shift-register serializer; emits one bit per DIV-clock
// bit period with bit_valid strobes and word_start/word_end framing.
module serial_word_feeder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     msb_first,
  output logic                     bit_out,
  output logic                     bit_valid,
  output logic                     word_start,
  output logic                     word_end,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(WIDTH);
  localparam int unsigned DW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0]   DIV_LOAD = DW'(DIV - 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_n;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  word_q, word_n;
  logic              msb_q, msb_n;
  logic [CW-1:0]     bit_q, bit_n;
  logic [DW-1:0]     div_q, div_n;
  logic [CW-1:0]     sel;
  logic [CNTW-1:0]   count_n;
  logic              push, pop;
  logic              bit_out_n, bit_valid_n, word_start_n, word_end_n, busy_n, in_ready_n;

  assign push = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state, pop decision and next registered outputs
  always_comb begin
    state_n = state_q;
    word_n  = word_q;
    msb_n   = msb_q;
    bit_n   = bit_q;
    div_n   = div_q;
    pop     = 1'b0;
    count_n = fifo_count;

    unique case (state_q)
      IDLE: begin
        if (fifo_count != '0) pop = 1'b1;
      end
      SHIFT: begin
        if (div_q == '0) begin
          if (bit_q == LAST_BIT) begin
            if (fifo_count != '0) pop = 1'b1;
            else                  state_n = IDLE;
          end else begin
            bit_n = bit_q + CW'(1);
            div_n = DIV_LOAD;
          end
        end else begin
          div_n = div_q - DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (pop) begin
      state_n = SHIFT;
      word_n  = mem[rd_ptr];
      msb_n   = msb_first;
      bit_n   = '0;
      div_n   = DIV_LOAD;
    end

    // Outputs are precomputed so they are registered alongside the state
    sel          = msb_n ? (LAST_BIT - bit_n) : bit_n;
    busy_n       = (state_n == SHIFT);
    bit_out_n    = busy_n && word_n[sel];
    bit_valid_n  = busy_n && (div_n == DIV_LOAD);
    word_start_n = bit_valid_n && (bit_n == '0);
    word_end_n   = bit_valid_n && (bit_n == LAST_BIT);

    unique case ({push, pop})
      2'b10:   count_n = fifo_count + CNTW'(1);
      2'b01:   count_n = fifo_count - CNTW'(1);
      default: count_n = fifo_count;
    endcase
    in_ready_n = (count_n < FULL_CNT);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q     <= '0;
      msb_q      <= 1'b0;
      bit_q      <= '0;
      div_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b1;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      word_start <= 1'b0;
      word_end   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      word_q     <= word_n;
      msb_q      <= msb_n;
      bit_q      <= bit_n;
      div_q      <= div_n;
      fifo_count <= count_n;
      in_ready   <= in_ready_n;
      bit_out    <= bit_out_n;
      bit_valid  <= bit_valid_n;
      word_start <= word_start_n;
      word_end   <= word_end_n;
      busy       <= busy_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: DIV=1 and DIV=3 instances, each checked every
// cycle against a queue-and-timeline reference model, plus directed scenarios.
module tb_serial_word_feeder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             msb_first;
  logic [WIDTH-1:0] in_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int unsigned D = (k == 0) ? 1 : 3;

    logic       in_ready, bit_out, bit_valid, word_start, word_end, busy;
    logic [2:0] fifo_count;
    int         n_valid, n_busy;

    serial_word_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(D)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .msb_first  (msb_first),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .word_start (word_start),
      .word_end   (word_end),
      .busy       (busy),
      .fifo_count (fifo_count)
    );

    // Reference: queue of words; active word described by clock index t within it
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] word;
    logic             msb;
    logic             active;
    int               t;

    initial begin
      logic             do_push;
      logic [WIDTH-1:0] d;
      logic             m;
      active = 1'b0; t = 0; word = '0; msb = 1'b0;
      forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
          q.delete();
          active = 1'b0;
          t = 0;
        end else begin
          do_push = in_valid && (q.size() < DEPTH);
          d = in_data;
          m = msb_first;
          if (!active || t == int'(WIDTH * D) - 1) begin
            if (q.size() > 0) begin
              word = q.pop_front();
              msb = m;
              t = 0;
              active = 1'b1;
            end else begin
              active = 1'b0;
            end
          end else begin
            t++;
          end
          if (do_push) q.push_back(d);
        end
      end
    end

    always @(negedge clk) begin : chk
      int    b;
      logic  ev, eb;
      string p;
      p  = (k == 0) ? "div1_" : "div3_";
      b  = t / int'(D);
      ev = active && (t % int'(D) == 0);
      eb = 1'b0;
      if (active) eb = msb ? word[WIDTH-1-b] : word[b];
      check({p, "in_ready"},   32'(in_ready),   32'(q.size() < DEPTH));
      check({p, "fifo_count"}, 32'(fifo_count), 32'(q.size()));
      check({p, "busy"},       32'(busy),       32'(active));
      check({p, "bit_valid"},  32'(bit_valid),  32'(ev));
      check({p, "bit_out"},    32'(bit_out),    32'(eb));
      check({p, "word_start"}, 32'(word_start), 32'(ev && b == 0));
      check({p, "word_end"},   32'(word_end),   32'(ev && b == int'(WIDTH) - 1));
    end

    // Strobe / busy-cycle counters since the last reset
    always @(negedge clk) begin
      if (reset) begin
        n_valid <= 0;
        n_busy  <= 0;
      end else begin
        if (bit_valid) n_valid <= n_valid + 1;
        if (busy)      n_busy  <= n_busy + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [WIDTH-1:0] d, input logic m);
    in_data = d;
    msb_first = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Follow one word on instance k from the push edge until it goes idle again
  task automatic capture(input int k, input string tag, input logic [WIDTH-1:0] exp_seq,
                         input int exp_busy);
    logic [WIDTH-1:0] seq = '0;
    int   nstr = 0, lat = 0, nbusy = 0, sidx = 0, eidx = 0;
    logic v, bo, s, e, bz, seen = 1'b0, done = 1'b0, idle_bit = 1'b1;
    for (int n = 1; n <= 120 && !done; n++) begin
      @(negedge clk);
      if (k == 0) {v, bo, s, e, bz} = {g_dut[0].bit_valid, g_dut[0].bit_out,
                                       g_dut[0].word_start, g_dut[0].word_end, g_dut[0].busy};
      else        {v, bo, s, e, bz} = {g_dut[1].bit_valid, g_dut[1].bit_out,
                                       g_dut[1].word_start, g_dut[1].word_end, g_dut[1].busy};
      if (v) begin
        nstr++;
        seq = {seq[WIDTH-2:0], bo};
        if (lat == 0) lat = n;
        if (s) sidx = nstr;
        if (e) eidx = nstr;
      end
      if (bz) begin
        nbusy++;
        seen = 1'b1;
      end else if (seen) begin
        done = 1'b1;
        idle_bit = bo;
      end
    end
    check({tag, "_done"},     32'(done),  32'(1));
    check({tag, "_seq"},      32'(seq),   32'(exp_seq));
    check({tag, "_strobes"},  32'(nstr),  32'(WIDTH));
    check({tag, "_latency"},  32'(lat),   32'(2));
    check({tag, "_busy_clk"}, 32'(nbusy), 32'(exp_busy));
    check({tag, "_start_at"}, 32'(sidx),  32'(1));
    check({tag, "_end_at"},   32'(eidx),  32'(WIDTH));
    check({tag, "_idle_bit"}, 32'(idle_bit), 32'(0));
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    msb_first = 1'b1;
    #3;
    check("rst_in_ready",   32'(g_dut[0].in_ready),   32'(1));
    check("rst_bit_valid",  32'(g_dut[0].bit_valid),  32'(0));
    check("rst_fifo_count", 32'(g_dut[1].fifo_count), 32'(0));
    repeat (2) tick();
    reset = 1'b0;

    // Single word, both bit orders, DIV=1
    do_reset();
    push_one(8'hB4, 1'b1);
    capture(0, "b4_msb", 8'hB4, 8);
    do_reset();
    push_one(8'hB4, 1'b0);
    capture(0, "b4_lsb", 8'b0010_1101, 8);

    // DIV=3 word timing
    do_reset();
    push_one(8'hA5, 1'b1);
    capture(1, "a5_div3", 8'hA5, 24);

    // Fill the FIFO: 5 back-to-back pushes saturate it, the 6th waits for a pop
    do_reset();
    msb_first = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h10 + 8'(i);
      tick();
    end
    in_data = 8'h15;
    @(negedge clk);
    check("full_count",    32'(g_dut[1].fifo_count), 32'(4));
    check("full_in_ready", 32'(g_dut[1].in_ready),   32'(0));
    guard = 0;
    while (!g_dut[1].in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("full_release", 32'(guard < 100), 32'(1));
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (g_dut[1].busy && guard < 300) begin
      tick();
      guard++;
    end
    check("burst_drained", 32'(guard < 300),       32'(1));
    check("burst_strobes", 32'(g_dut[1].n_valid),  32'(6 * WIDTH));
    check("burst_nogap",   32'(g_dut[1].n_busy),   32'(6 * WIDTH * 3));

    // Asynchronous reset in the middle of a word with three words queued
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    guard = 0;
    while (g_dut[1].n_valid < 4 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("mid_reached_bit3", 32'(g_dut[1].n_valid), 32'(4));
    check("mid_queued",       32'(g_dut[1].fifo_count), 32'(3));
    tick();
    reset = 1'b1;
    #1;
    check("arst_busy",       32'(g_dut[1].busy),       32'(0));
    check("arst_bit_valid",  32'(g_dut[1].bit_valid),  32'(0));
    check("arst_bit_out",    32'(g_dut[1].bit_out),    32'(0));
    check("arst_fifo_count", 32'(g_dut[1].fifo_count), 32'(0));
    check("arst_in_ready",   32'(g_dut[1].in_ready),   32'(1));
    check("arst_framing",    32'({g_dut[1].word_start, g_dut[1].word_end}), 32'(0));
    tick();
    reset = 1'b0;
    repeat (30) tick();
    check("post_rst_quiet0", 32'(g_dut[0].n_valid), 32'(0));
    check("post_rst_quiet1", 32'(g_dut[1].n_valid), 32'(0));

    // Random traffic, bit order and occasional resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      msb_first = 1'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    repeat (200) tick();
    check("final_idle0", 32'(g_dut[0].busy), 32'(0));
    check("final_idle1", 32'(g_dut[1].busy), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
